alu_exec_control: RTL
=====================

Name: alu_exec_control

Overview:
- Next-generation ALU control for the multi-cycle datapath.
- Decodes ALUOp/funct into the 4-bit ALU operation with the full 6-bit funct, and adds nor, mult/multu/div/divu and mfhi/mflo.
- Multiply/divide runs on an internal iterative sequencer with HI/LO registers.
- Drives stall to the hazard unit while a HI/LO consumer or a second mul/div arrives during an operation.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits

Ports:
clk        input   1      system clock, rising edge
rstn       input   1      asynchronous active-low reset
alu_op     input   2      ALUOp from main control
funct      input   6      instruction funct field
issue      input   1      instruction in EX is valid this cycle
flush      input   1      synchronous abort of any in-flight mul/div
src_a      input   WIDTH  rs operand (multiplicand / dividend)
src_b      input   WIDTH  rt operand (multiplier / divisor)
operation  output  4      ALU operation, combinational
hilo_sel   output  2      00 ALU result, 01 HI, 10 LO; combinational
busy       output  1      sequencer not idle
stall      output  1      hold EX; combinational
done       output  1      one-cycle pulse, new HI/LO valid
hi         output  WIDTH  HI register
lo         output  WIDTH  LO register

Behaviour:
- Interface: one clock `clk`. Reset `rstn` is asynchronous and active-low.
- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0.
- Decode (pure combinational, independent of state and issue):
  - alu_op 00: operation 0010 (add).
  - alu_op 01: operation 0110 (sub).
  - alu_op 11: operation 0000 (reserved).
  - alu_op 10, decoded on funct:
    - 100000: 0010.
    - 100010: 0110.
    - 100100: 0000.
    - 100101: 0001.
    - 100111: 1100 (nor).
    - 101010: 0111 (slt).
    - 011000 mult, 011001 multu, 011010 div, 011011 divu: 0010.
    - 010000 mfhi: 0010, hilo_sel 01.
    - 010010 mflo: 0010, hilo_sel 10.
    - Any other funct: 0000.
  - hilo_sel is 00 in every case except mfhi/mflo.
- Acceptance: a mul/div is accepted at an edge when issue=1, the funct is in the mul/div family with alu_op=10, state=IDLE and flush=0.
  - src_a, src_b and the op kind are captured at that edge.
  - Later operand changes are ignored.
- States:
  - IDLE -> RUN on acceptance.
  - RUN -> FIX after WIDTH iterations, counter loaded with WIDTH.
  - FIX -> IDLE after one cycle.
- Iteration:
  - Multiply: shift-add, one multiplier bit per RUN cycle, 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Signed ops iterate on magnitudes.
- FIX cycle:
  - Product is negated when operand signs differ.
  - Quotient is negated when signs differ; remainder takes the dividend's sign.
- Result write:
  - hi/lo are written at the FIX->IDLE edge.
  - Multiply: hi = product upper half, lo = product lower half.
  - Divide: lo = quotient, hi = remainder.
- Latency: busy is high for exactly WIDTH+1 cycles after the accept edge.
  - done is high in the first IDLE cycle only.
  - mfhi/mflo issued in that cycle reads the new values.
- Divide by zero: lo = all ones, hi = captured src_a; full latency.
  - Signed most-negative/-1 gives lo = most-negative, hi = 0.
- Stall: stall = issue & busy & (mul/div family | mfhi | mflo), with alu_op=10.
  - Other R-type and non-R ops never stall.
  - A stalled mul/div is not accepted; it is accepted when it re-presents after busy falls.
- Flush:
  - In RUN/FIX: next state IDLE, hi/lo unchanged, no done pulse.
  - flush with issue in IDLE: nothing accepted.
- Mid-operation rstn low: immediate IDLE and hi/lo=0 regardless of clock.
- Back-to-back: a mul/div issued in the done cycle is accepted; done still pulses.

Optional Feature:
- Macro: ALU_EXEC_EARLY_OUT_EN.
- Defined:
  - For mult/multu, after each RUN iteration, if the remaining unshifted multiplier magnitude is zero, the next state is FIX.
  - Resulting busy time = (index of highest set multiplier-magnitude bit + 1) + 1 cycles, minimum 2 cycles for multiplier 0.
  - Divide is unaffected.
- Undefined: every operation takes WIDTH+1 busy cycles.
- Results are identical either way.

Test Plan:
1. Decode, no clock needed:
   - alu_op=10, funct=100111 -> operation 1100.
   - funct=101010 -> 0111.
   - funct=010000 -> hilo_sel 01.
   - alu_op=01 -> 0110.
   - alu_op=11 -> 0000.
2. WIDTH=32, mult src_a=FFFFFFF9 (-7), src_b=00000006 -> busy 33 cycles, done one cycle, hi=FFFFFFFF, lo=FFFFFFD6. multu FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
3. div FFFFFFF9/00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. divu 00000007/0 -> lo=FFFFFFFF, hi=00000007. div 80000000/FFFFFFFF -> lo=80000000, hi=0.
4. Stall behaviour during a running mult:
   - mfhi held with issue=1 the cycle after the mult -> stall=1 for 33 cycles, 0 in the done cycle, reads new HI.
   - An add issued while busy -> stall=0.
5. Abort behaviour:
   - flush at RUN cycle 10 of a mult (prior hi/lo = 1/2) -> busy=0 next cycle, no done, hi=1, lo=2.
   - rstn low mid-div -> busy=0 and hi=lo=0 asynchronously.
6. With ALU_EXEC_EARLY_OUT_EN: mult 5*3 -> busy 3 cycles. mult x*0 -> busy 2 cycles. Without the macro: both 33 cycles, same results.

Source files
------------

// File: rtl/alu_exec_control.sv
// rtl/alu_exec_control.sv - ALU control decode plus iterative mul/div sequencer with HI/LO
// Optional ALU_EXEC_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module alu_exec_control #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             issue,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       operation,
    output logic [1:0]       hilo_sel,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               is_muldiv;
    logic               is_mfhi;
    logic               is_mflo;
    logic               accept;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               early_out;

    always_comb begin
        operation = 4'b0000;
        hilo_sel  = 2'b00;
        case (alu_op)
            2'b00: operation = 4'b0010;
            2'b01: operation = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100000: operation = 4'b0010;
                    6'b100010: operation = 4'b0110;
                    6'b100100: operation = 4'b0000;
                    6'b100101: operation = 4'b0001;
                    6'b100111: operation = 4'b1100;
                    6'b101010: operation = 4'b0111;
                    6'b011000, 6'b011001,
                    6'b011010, 6'b011011: operation = 4'b0010;
                    6'b010000: begin
                        operation = 4'b0010;
                        hilo_sel  = 2'b01;
                    end
                    6'b010010: begin
                        operation = 4'b0010;
                        hilo_sel  = 2'b10;
                    end
                    default: operation = 4'b0000;
                endcase
            end
            default: operation = 4'b0000;
        endcase
    end

    assign is_muldiv = (alu_op == 2'b10) && (funct[5:2] == 4'b0110);
    assign is_mfhi   = (alu_op == 2'b10) && (funct == 6'b010000);
    assign is_mflo   = (alu_op == 2'b10) && (funct == 6'b010010);
    assign stall     = issue & busy & (is_muldiv | is_mfhi | is_mflo);
    assign accept    = issue & is_muldiv & (state == IDLE) & ~flush;

    // funct[0]=0 selects the signed variants; iteration runs on magnitudes
    assign op_signed = ~funct[0];
    assign a_mag     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // Divide keeps the partial remainder in acc's upper half, dividend/quotient in the lower
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = rem_sh >= {1'b0, mplier};
    assign rem_diff = rem_sh[WIDTH-1:0] - mplier;

    always_comb begin
        acc_step = acc;
        if (op_div)
            acc_step = {(div_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        else
            acc_step = acc + (mplier[0] ? mcand : '0);
    end

    assign prod   = neg_q ? -acc : acc;
    assign quot   = acc[WIDTH-1:0];
    assign rem    = acc[2*WIDTH-1:WIDTH];
    assign res_lo = op_div ? (div_zero ? '1 : (neg_q ? -quot : quot)) : prod[WIDTH-1:0];
    assign res_hi = op_div ? (neg_r ? -rem : rem) : prod[2*WIDTH-1:WIDTH];

`ifdef ALU_EXEC_EARLY_OUT_EN
    assign early_out = !op_div && (mplier[WIDTH-1:1] == '0);
`else
    assign early_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        cnt      <= CW'(WIDTH);
                        op_div   <= funct[1];
                        neg_q    <= op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_r    <= op_signed & funct[1] & src_a[WIDTH-1];
                        div_zero <= funct[1] & (src_b == '0);
                        mcand    <= {{WIDTH{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        acc      <= funct[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_step;
                        cnt <= cnt - CW'(1);
                        if (!op_div) begin
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                        end
                        if (cnt == CW'(1) || early_out)
                            state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
